bg_vram_rd_responder: RTL and testbench
=======================================

Name: bg_vram_rd_responder

Overview:
- Responder end of the BG processing circuit's VRAM fetch interface: accepts tile-map and tile-data read requests from the BG fetch initiator, issues them to the VRAM array, and returns read data in order through a backpressured response FIFO.
- The CPU write port shares the same VRAM array and has priority over BG reads.
- Sits between the BG processing circuit and the VRAM macro.

Parameters:
- ADDR_W, 15, word-address width (96 KB VRAM / 32-bit words).
- DATA_W, 32, read/write data width.
- MEM_LAT, 2, fixed VRAM read latency in cycles (legal range 1..4).
- DEPTH, 4, response FIFO entries (power of 2, >= MEM_LAT).

Ports:
- clk  input  1  clock, positive edge
- rst_b  input  1  asynchronous active-low reset
- flush  input  1  synchronous drop of all queued and in-flight responses (scanline start)
- req_valid  input  1  BG read request valid
- req_ready  output  1  responder can accept request this cycle
- req_addr  input  ADDR_W  BG read word address
- rsp_valid  output  1  response data available
- rsp_ready  input  1  BG consumes response
- rsp_data  output  DATA_W  response data, FIFO head
- cpu_we  input  1  CPU write strobe
- cpu_addr  input  ADDR_W  CPU write address
- cpu_wdata  input  DATA_W  CPU write data
- mem_re  output  1  VRAM read enable
- mem_we  output  1  VRAM write enable
- mem_addr  output  ADDR_W  VRAM address
- mem_wdata  output  DATA_W  VRAM write data
- mem_rdata  input  DATA_W  VRAM read data, valid MEM_LAT cycles after mem_re

Behaviour:
- Reset (rst_b low, asynchronous):
  - FIFO pointers, count, in-flight pipe and all registered state go to 0.
  - Outputs while rst_b low: req_ready=0, rsp_valid=0, rsp_data=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Credit rule:
  - inflight = number of set bits in the MEM_LAT-long valid shift pipe.
  - req_ready = ~cpu_we & ~flush & (inflight + count < DEPTH).
  - This guarantees the FIFO can never overflow.
- Accept: req_valid & req_ready in cycle N gives, combinationally in cycle N, mem_re=1 and mem_addr=req_addr. Valid bit enters the pipe at position 0.
- Return:
  - A pipe bit exits at cycle N+MEM_LAT.
  - mem_rdata is pushed into the FIFO at the edge ending cycle N+MEM_LAT.
  - rsp_valid is high from cycle N+MEM_LAT+1.
  - Minimum request-to-response latency is MEM_LAT+1.
- CPU write:
  - While cpu_we=1: mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_re=0, req_ready=0.
  - In-flight reads still return normally.
- Ordering: responses are returned strictly in request order. No tags.
- FIFO:
  - rsp_valid = (count != 0).
  - rsp_data = head entry, held stable while rsp_valid & ~rsp_ready.
  - Pop on rsp_valid & rsp_ready.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged, both pointers advance (including at count==DEPTH-1 and count==1).
  - Pop when empty: cannot occur, since rsp_valid=0.
  - Push when full: prevented by the credit rule.
- Pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits.
- Throughput: 1 request/cycle sustained while rsp_ready=1 and no cpu_we. With rsp_ready stalled, at most DEPTH requests are outstanding in total.
- flush (synchronous, highest priority after reset):
  - Clears count, pointers and the valid pipe.
  - Data returning later for flushed requests is discarded.
  - req_ready=0 in the flush cycle.
  - rsp_valid=0 from the next cycle.
- Reset mid-operation: all in-flight and queued responses are lost. The first request after rst_b rises behaves as from idle.

Optional Feature:
- Macro BG_VRAM_RSP_ADDR_EN.
- Defined:
  - Adds output rsp_addr [ADDR_W-1:0], the address of the head response, carried through the valid pipe and FIFO alongside the data.
  - rsp_addr resets to 0 and obeys the same hold rules as rsp_data.
- Undefined: port absent, no address storage.

Test Plan:
- Single read: MEM_LAT=2, memory word 0x0100 = 0xDEADBEEF, request at cycle 10 with rsp_ready=1 -> mem_re=1, mem_addr=0x0100 in cycle 10; rsp_valid=1, rsp_data=0xDEADBEEF in cycle 13 only.
- Streaming: 8 back-to-back requests, addresses 0..7 holding data 0x10+i, rsp_ready=1 -> req_ready stays 1; responses 0x10..0x17 in order on 8 consecutive cycles.
- Backpressure: rsp_ready=0, requests issued every cycle -> exactly DEPTH=4 accepted, then req_ready=0; raise rsp_ready -> 4 responses drain in order, req_ready returns to 1 once credit frees.
- CPU priority: cpu_we=1 (addr 0x20, data 0xA5A5A5A5) with req_valid=1 in the same cycle -> mem_we=1, mem_re=0, req_ready=0; read of 0x20 issued the next cycle returns 0xA5A5A5A5.
- Flush: 2 requests in flight plus 2 queued, then flush=1 -> rsp_valid=0 next cycle; no stale data ever appears; a fresh request then returns correct data after MEM_LAT+1.
- Async reset: rst_b pulsed low mid-stream -> all outputs 0 immediately; after release, req_ready=1 and rsp_valid stays 0 until a new request returns.

Source files
------------

// File: rtl/bg_vram_rd_responder.sv
// BG VRAM read responder: credit-gated read issue, fixed-latency return pipe and in-order response FIFO.
// Optional define BG_VRAM_RSP_ADDR_EN adds rsp_addr carried alongside the read data.
module bg_vram_rd_responder #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2,
  parameter int DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
`ifdef BG_VRAM_RSP_ADDR_EN
  output logic [ADDR_W-1:0] rsp_addr,
`endif
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;

  logic [MEM_LAT-1:0] vld_r;
  logic [DATA_W-1:0]  fifo_data_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [SUM_W-1:0]   inflight_s;
  logic [SUM_W-1:0]   occupancy_s;
  logic               credit_ok_s;
  logic               accept_s;
  logic               push_s;
  logic               pop_s;

  // Reads in flight: popcount of the return pipe.
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      inflight_s = inflight_s + SUM_W'(vld_r[i]);
    end
  end

  // Every in-flight read already owns a FIFO slot, so the FIFO cannot overflow.
  assign occupancy_s = inflight_s + SUM_W'(count_r);
  assign credit_ok_s = (occupancy_s < SUM_W'(DEPTH));
  assign req_ready   = rst_b & ~cpu_we & ~flush & credit_ok_s;
  assign accept_s    = req_valid & req_ready;
  assign push_s      = vld_r[MEM_LAT-1];
  assign rsp_valid   = (count_r != CNT_W'(0));
  assign pop_s       = rsp_valid & rsp_ready;
  assign rsp_data    = fifo_data_r[rd_ptr_r];

  // VRAM port mux: CPU write wins over BG read; everything quiet in reset.
  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst_b) begin
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end else if (cpu_we) begin
      mem_re    = 1'b0;
      mem_we    = 1'b1;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else begin
      mem_re    = accept_s;
      mem_we    = 1'b0;
      mem_addr  = req_addr;
      mem_wdata = '0;
    end
  end

  // Return valid pipe; a bit leaving the top marks mem_rdata as live.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vld_r <= '0;
    end else if (flush) begin
      vld_r <= '0;
    end else begin
      for (int i = MEM_LAT - 1; i > 0; i--) begin
        vld_r[i] <= vld_r[i-1];
      end
      vld_r[0] <= accept_s;
    end
  end

  // Response FIFO storage.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data_r[i] <= '0;
      end
    end else if (push_s && !flush) begin
      fifo_data_r[wr_ptr_r] <= mem_rdata;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef BG_VRAM_RSP_ADDR_EN
  logic [ADDR_W-1:0] addr_pipe_r [MEM_LAT];
  logic [ADDR_W-1:0] fifo_addr_r [DEPTH];

  // Request address travels with its valid bit, then into the FIFO beside the data.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        addr_pipe_r[i] <= '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_r[i] <= '0;
      end
    end else begin
      for (int i = MEM_LAT - 1; i > 0; i--) begin
        addr_pipe_r[i] <= addr_pipe_r[i-1];
      end
      addr_pipe_r[0] <= req_addr;
      if (push_s && !flush) begin
        fifo_addr_r[wr_ptr_r] <= addr_pipe_r[MEM_LAT-1];
      end
    end
  end

  assign rsp_addr = fifo_addr_r[rd_ptr_r];
`endif

endmodule

// File: tb/tb_bg_vram_rd_responder.sv
// Directed bench for bg_vram_rd_responder: per-cycle vector table plus hand sequences
// for backpressure, flush and asynchronous reset.
module tb_bg_vram_rd_responder;

  localparam int AW  = 15;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int DEP = 4;

  logic          clk = 1'b0;
  logic          rst_b = 1'b1;
  logic          flush = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
`ifdef BG_VRAM_RSP_ADDR_EN
  logic [AW-1:0] rsp_addr;
`endif
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          mem_re;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  bg_vram_rd_responder #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .DEPTH(DEP)
  ) dut (
    .clk(clk), .rst_b(rst_b), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
`ifdef BG_VRAM_RSP_ADDR_EN
    .rsp_addr(rsp_addr),
`endif
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // VRAM model: fixed contents plus one CPU-writable word, LAT-cycle read pipe.
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    if (a == 15'h0100) return 32'hDEADBEEF;
    return 32'h0000_0010 + 32'(a);
  endfunction

  logic          wr_seen = 1'b0;
  logic [AW-1:0] wr_addr_m = '0;
  logic [DW-1:0] wr_data_m = '0;
  logic [DW-1:0] rd_pipe [LAT];

  always @(posedge clk) begin
    if (mem_re) rd_pipe[0] <= (wr_seen && mem_addr == wr_addr_m) ? wr_data_m : init_word(mem_addr);
    else        rd_pipe[0] <= 32'h0BAD_0BAD;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_we) begin
      wr_seen   <= 1'b1;
      wr_addr_m <= mem_addr;
      wr_data_m <= mem_wdata;
    end
  end
  assign mem_rdata = rd_pipe[LAT-1];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic          rv;
    logic [AW-1:0] ra;
    logic          cw;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic          e_rr;
    logic          e_re;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic          e_rv;
    logic [DW-1:0] e_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t rd_row(input logic rv, input logic [AW-1:0] ra,
                                  input logic e_rv, input logic [DW-1:0] e_rd);
    vec_t v;
    v.rv = rv; v.ra = ra; v.cw = 1'b0; v.ca = '0; v.cd = '0;
    v.e_rr = 1'b1; v.e_re = rv; v.e_we = 1'b0; v.e_addr = ra;
    v.e_rv = e_rv; v.e_rd = e_rd;
    return v;
  endfunction

  initial begin
    vec_t c;
    int acc;

    // Reset state with busy-looking inputs.
    #1 rst_b = 1'b0;
    req_valid = 1'b1; req_addr = 15'h0123; cpu_we = 1'b1;
    cpu_addr = 15'h7FFF; cpu_wdata = 32'hFFFF_FFFF; rsp_ready = 1'b1;
    #1;
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_data",  rsp_data, 32'd0);
    chk("rst.mem_re",    32'(mem_re), 32'd0);
    chk("rst.mem_we",    32'(mem_we), 32'd0);
    chk("rst.mem_addr",  32'(mem_addr), 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1; req_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

    // Single read (t0..t4), CPU priority (t5..t9), 8-deep streaming (t10..t21).
    tbl.push_back(rd_row(1'b1, 15'h0100, 1'b0, 32'h0));
    tbl.push_back(rd_row(1'b0, 15'h0000, 1'b0, 32'h0));
    tbl.push_back(rd_row(1'b0, 15'h0000, 1'b0, 32'h0));
    tbl.push_back(rd_row(1'b0, 15'h0000, 1'b1, 32'hDEADBEEF));
    tbl.push_back(rd_row(1'b0, 15'h0000, 1'b0, 32'h0));
    c = rd_row(1'b1, 15'h0020, 1'b0, 32'h0);
    c.cw = 1'b1; c.ca = 15'h0020; c.cd = 32'hA5A5A5A5;
    c.e_rr = 1'b0; c.e_re = 1'b0; c.e_we = 1'b1;
    tbl.push_back(c);
    tbl.push_back(rd_row(1'b1, 15'h0020, 1'b0, 32'h0));
    tbl.push_back(rd_row(1'b0, 15'h0000, 1'b0, 32'h0));
    tbl.push_back(rd_row(1'b0, 15'h0000, 1'b0, 32'h0));
    tbl.push_back(rd_row(1'b0, 15'h0000, 1'b1, 32'hA5A5A5A5));
    for (int i = 0; i < 11; i++)
      tbl.push_back(rd_row(i < 8, 15'(i), i >= 3, 32'h10 + 32'(i - 3)));
    tbl.push_back(rd_row(1'b0, 15'h0000, 1'b0, 32'h0));

    foreach (tbl[k]) begin
      @(negedge clk);
      req_valid = tbl[k].rv; req_addr = tbl[k].ra;
      cpu_we = tbl[k].cw; cpu_addr = tbl[k].ca; cpu_wdata = tbl[k].cd;
      #1;
      chk($sformatf("row%0d.req_ready", k), 32'(req_ready), 32'(tbl[k].e_rr));
      chk($sformatf("row%0d.mem_re", k),    32'(mem_re),    32'(tbl[k].e_re));
      chk($sformatf("row%0d.mem_we", k),    32'(mem_we),    32'(tbl[k].e_we));
      chk($sformatf("row%0d.rsp_valid", k), 32'(rsp_valid), 32'(tbl[k].e_rv));
      if (tbl[k].e_re || tbl[k].e_we)
        chk($sformatf("row%0d.mem_addr", k), 32'(mem_addr), 32'(tbl[k].e_addr));
      if (tbl[k].e_we)
        chk($sformatf("row%0d.mem_wdata", k), mem_wdata, tbl[k].cd);
      if (tbl[k].e_rv)
        chk($sformatf("row%0d.rsp_data", k), rsp_data, tbl[k].e_rd);
    end
    req_valid = 1'b0; cpu_we = 1'b0;

    // Backpressure: only DEPTH requests are accepted while rsp_ready is low.
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_addr = 15'(i);
      #1;
      chk($sformatf("bp%0d.req_ready", i), 32'(req_ready), 32'(i < DEP));
      if (req_valid && req_ready) acc++;
    end
    chk("bp.accepted", 32'(acc), 32'(DEP));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk("bp.hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp.hold_data", rsp_data, 32'h10);
      chk("bp.full_ready", 32'(req_ready), 32'd0);
    end
    for (int k = 0; k < DEP; k++) begin
      @(negedge clk);
      rsp_ready = 1'b1;
      #1;
      chk($sformatf("drain%0d.rsp_valid", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("drain%0d.rsp_data", k), rsp_data, 32'h10 + 32'(k));
      chk($sformatf("drain%0d.req_ready", k), 32'(req_ready), 32'(k != 0));
    end
    @(negedge clk); #1;
    chk("drain.empty", 32'(rsp_valid), 32'd0);

    // Flush with 2 queued and 2 in flight.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_addr = 15'(4 + i);
      #1;
      chk($sformatf("fl_req%0d.req_ready", i), 32'(req_ready), 32'd1);
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush.req_ready", 32'(req_ready), 32'd0);
    chk("flush.mem_re", 32'(mem_re), 32'd0);
    chk("flush.rsp_valid_before", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      flush = 1'b0; req_valid = 1'b0;
      #1;
      chk($sformatf("postflush%0d.rsp_valid", i), 32'(rsp_valid), 32'd0);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = (i == 0); req_addr = 15'h0100;
      #1;
      if (i == 0) chk("fresh.mem_re", 32'(mem_re), 32'd1);
      chk($sformatf("fresh%0d.rsp_valid", i), 32'(rsp_valid), 32'(i == 3));
      if (i == 3) begin
        chk("fresh.rsp_data", rsp_data, 32'hDEADBEEF);
`ifdef BG_VRAM_RSP_ADDR_EN
        chk("fresh.rsp_addr", 32'(rsp_addr), 32'h0100);
`endif
      end
    end
    req_valid = 1'b0;

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_addr = 15'(i);
      #1;
    end
    chk("stream.rsp_valid", 32'(rsp_valid), 32'd1);
    #1;
    cpu_we = 1'b1; cpu_addr = 15'h0055; cpu_wdata = 32'h1234_5678;
    rst_b = 1'b0;
    #1;
    chk("arst.req_ready", 32'(req_ready), 32'd0);
    chk("arst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst.rsp_data",  rsp_data, 32'd0);
    chk("arst.mem_re",    32'(mem_re), 32'd0);
    chk("arst.mem_we",    32'(mem_we), 32'd0);
    chk("arst.mem_addr",  32'(mem_addr), 32'd0);
    chk("arst.mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_b = 1'b1; cpu_we = 1'b0; req_valid = 1'b0;
    #1;
    chk("arst_rel.req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk($sformatf("arst_idle%0d.rsp_valid", i), 32'(rsp_valid), 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = (i == 0); req_addr = 15'h0006;
      #1;
      chk($sformatf("arst_new%0d.rsp_valid", i), 32'(rsp_valid), 32'(i == 3));
      if (i == 3) chk("arst_new.rsp_data", rsp_data, 32'h16);
    end
    req_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
